univ_shift_reg_sr: RTL and testbench

- Parametrised WIDTH-bit universal shift register built from edge-triggered D flip-flop cells; successor to the single-bit D latch with set/reset.
- Adds synchronous set and clear, clock enable, parallel load, shift/rotate in both directions, and bitwise invert.
- Drives true and complemented outputs (q, q_n), matching the latch's output pair.
- Used as a general register/serialiser stage in the lab datapath.

---
 rtl/usr_pkg.sv | 15 +
 rtl/univ_shift_reg_sr_if.sv | 31 +++
 rtl/usr_cell.sv | 47 ++++
 rtl/univ_shift_reg_sr.sv | 55 +++++
 tb/tb_univ_shift_reg_sr.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation-select codes.
package usr_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHR  = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_LOAD = 3'b011;
  localparam mode_t MODE_ROR  = 3'b100;
  localparam mode_t MODE_ROL  = 3'b101;
  localparam mode_t MODE_INV  = 3'b110;
  localparam mode_t MODE_RSVD = 3'b111;

endpackage

// File: rtl/univ_shift_reg_sr_if.sv
// Control/data bus of the universal shift register, split into master/slave views.
interface univ_shift_reg_sr_if #(
  parameter int WIDTH = 8
);
  import usr_pkg::*;

  // No handshake: every control and data field is sampled on every rising clk edge.
  // The outputs are valid continuously and reflect the state after the last edge.
  logic             clr;
  logic             set;
  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             so_r;
  logic             so_l;

  modport master (
    output clr, set, en, mode, d, sin_r, sin_l,
    input  q, q_n, so_r, so_l
  );

  modport slave (
    input  clr, set, en, mode, d, sin_r, sin_l,
    output q, q_n, so_r, so_l
  );

endinterface

// File: rtl/usr_cell.sv
// One register bit: mode mux plus a D flip-flop with reset > clr > set > en priority.
module usr_cell
  import usr_pkg::*;
#(
  parameter logic INIT_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  i_reset,
  input  logic  i_clr,
  input  logic  i_set,
  input  logic  i_en,
  input  mode_t i_mode,
  input  logic  i_d,
  input  logic  i_from_left,
  input  logic  i_from_right,
  output logic  o_q
);

  logic r_q;
  logic w_next;

  // from_left feeds right-moving ops, from_right feeds left-moving ops.
  always_comb begin
    w_next = r_q;
    case (i_mode)
      MODE_HOLD: w_next = r_q;
      MODE_SHR:  w_next = i_from_left;
      MODE_SHL:  w_next = i_from_right;
      MODE_LOAD: w_next = i_d;
      MODE_ROR:  w_next = i_from_left;
      MODE_ROL:  w_next = i_from_right;
      MODE_INV:  w_next = ~r_q;
      MODE_RSVD: w_next = r_q;
      default:   w_next = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset)      r_q <= INIT_BIT;
    else if (i_clr)   r_q <= 1'b0;
    else if (i_set)   r_q <= 1'b1;
    else if (i_en)    r_q <= w_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg_sr.sv
// WIDTH-bit universal shift register: load, shift/rotate both ways, invert, set/clear.
module univ_shift_reg_sr
  import usr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic               clk,
  input  logic               reset,
  univ_shift_reg_sr_if.slave bus
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_from_left;
  logic [WIDTH-1:0] w_from_right;

  // End bits take the serial input on a shift and the opposite end bit on a rotate.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i == WIDTH - 1) begin : g_msb
        assign w_from_left[i] = (bus.mode == MODE_ROR) ? w_q[0] : bus.sin_r;
      end else begin : g_mid_l
        assign w_from_left[i] = w_q[i+1];
      end

      if (i == 0) begin : g_lsb
        assign w_from_right[i] = (bus.mode == MODE_ROL) ? w_q[WIDTH-1] : bus.sin_l;
      end else begin : g_mid_r
        assign w_from_right[i] = w_q[i-1];
      end

      usr_cell #(
        .INIT_BIT (INIT[i])
      ) u_cell (
        .clk          (clk),
        .i_reset      (reset),
        .i_clr        (bus.clr),
        .i_set        (bus.set),
        .i_en         (bus.en),
        .i_mode       (bus.mode),
        .i_d          (bus.d[i]),
        .i_from_left  (w_from_left[i]),
        .i_from_right (w_from_right[i]),
        .o_q          (w_q[i])
      );
    end
  endgenerate

  assign bus.q    = w_q;
  assign bus.q_n  = ~w_q;
  assign bus.so_r = w_q[0];
  assign bus.so_l = w_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg_sr.sv
// Directed bench for univ_shift_reg_sr (WIDTH=8, INIT=0) with an expected-value queue.
module tb_univ_shift_reg_sr;
  import usr_pkg::*;

  localparam int W = 8;

  logic clk;
  logic reset;
  logic chk_req;
  int   checks;
  int   failures;
  int   mon_idx;

  logic [W-1:0] exp_q[$];

  univ_shift_reg_sr_if #(.WIDTH(W)) bus ();

  univ_shift_reg_sr #(
    .WIDTH (W),
    .INIT  (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, pending=%0d", exp_q.size());
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // driver: inputs change 1 time unit after a rising edge, take effect on the next one
  task automatic step(input logic rst, input logic c, input logic s, input logic e,
                      input mode_t m, input logic [W-1:0] dv, input logic sr,
                      input logic sl, input logic [W-1:0] exp_val);
    @(posedge clk);
    #1;
    reset     = rst;
    bus.clr   = c;
    bus.set   = s;
    bus.en    = e;
    bus.mode  = m;
    bus.d     = dv;
    bus.sin_r = sr;
    bus.sin_l = sl;
    chk_req   = 1'b1;
    exp_q.push_back(exp_val);
  endtask

  task automatic op(input mode_t m, input logic sr, input logic sl,
                    input logic [W-1:0] exp_val);
    step(1'b0, 1'b0, 1'b0, 1'b1, m, 8'h00, sr, sl, exp_val);
  endtask

  task automatic load(input logic [W-1:0] dv);
    step(1'b0, 1'b0, 1'b0, 1'b1, MODE_LOAD, dv, 1'b0, 1'b0, dv);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, mon_idx, act, req);
    end
  endtask

  // scoreboard monitor: after each requested edge, compare on the falling edge
  always @(posedge clk) begin
    if (chk_req) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL underflow step=%0d actual=empty required=entry", mon_idx);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("q",    bus.q,    e);
        check("q_n",  bus.q_n,  ~e);
        check("so_r", {7'b0, bus.so_r}, {7'b0, e[0]});
        check("so_l", {7'b0, bus.so_l}, {7'b0, e[W-1]});
      end
      mon_idx++;
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    mon_idx   = 0;
    chk_req   = 1'b0;
    reset     = 1'b1;
    bus.clr   = 1'b0;
    bus.set   = 1'b0;
    bus.en    = 1'b0;
    bus.mode  = MODE_HOLD;
    bus.d     = '0;
    bus.sin_r = 1'b0;
    bus.sin_l = 1'b0;

    // reset beats everything, clr beats set, set beats a load
    step(1'b1, 1'b1, 1'b1, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 1'b1, 1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 1'b1, MODE_INV,  8'h00, 1'b0, 1'b0, 8'h00);

    // load and hold (en low, then mode hold)
    load(8'hA5);
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 1'b0, 1'b0, MODE_SHR, 8'hFF, 1'b1, 1'b1, 8'hA5);
    op(MODE_HOLD, 1'b1, 1'b1, 8'hA5);

    // shift right, then left
    op(MODE_SHR, 1'b1, 1'b0, 8'hD2);
    op(MODE_SHR, 1'b0, 1'b0, 8'h69);
    load(8'hA5);
    op(MODE_SHL, 1'b0, 1'b0, 8'h4A);
    op(MODE_SHL, 1'b1, 1'b0, 8'h94);

    // rotates, including a full lap
    load(8'h81);
    op(MODE_ROL, 1'b0, 1'b0, 8'h03);
    op(MODE_ROR, 1'b0, 1'b0, 8'h81);
    op(MODE_ROR, 1'b0, 1'b0, 8'hC0);
    op(MODE_ROR, 1'b0, 1'b0, 8'h60);
    op(MODE_ROR, 1'b0, 1'b0, 8'h30);
    op(MODE_ROR, 1'b0, 1'b0, 8'h18);
    op(MODE_ROR, 1'b0, 1'b0, 8'h0C);
    op(MODE_ROR, 1'b0, 1'b0, 8'h06);
    op(MODE_ROR, 1'b0, 1'b0, 8'h03);
    op(MODE_ROR, 1'b0, 1'b0, 8'h81);

    // invert, reserved, reset in the middle of a shift run
    load(8'h3C);
    op(MODE_INV,  1'b0, 1'b0, 8'hC3);
    op(MODE_RSVD, 1'b1, 1'b1, 8'hC3);
    op(MODE_SHR,  1'b0, 1'b0, 8'h61);
    step(1'b1, 1'b0, 1'b0, 1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0, 8'h00);
    op(MODE_SHR,  1'b1, 1'b0, 8'h80);
    op(MODE_SHR,  1'b1, 1'b0, 8'hC0);

    @(posedge clk);
    #1;
    chk_req = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
